pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the stall inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline flops, plus their flush (bubble) controls and PC hold. It covers four cases: load-use hazards, multi-cycle data-memory waits, taken branches resolved in MEM, and halt drain. It sits beside the datapath and observes only control fields already carried in the pipeline flops.

Parameters:
MEM_WAIT_MAX, 8, max consecutive memory-wait cycles before mem_timeout asserts (legal 1..255)
CNT_W, 16, width of optional performance counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
re_mem_EX  input  1  EX-stage instruction is a load
we_rf_EX  input  1  EX-stage instruction writes the register file
dst_addr_EX  input  4  EX-stage destination register
p0_addr_ID  input  4  ID-stage source register 0
p1_addr_ID  input  4  ID-stage source register 1
p0_used_ID  input  1  ID-stage instruction reads p0
p1_used_ID  input  1  ID-stage instruction reads p1
we_mem_MEM  input  1  MEM-stage store
re_mem_MEM  input  1  MEM-stage load
mem_rdy  input  1  data memory completes the MEM-stage access this cycle
b_ctrl_MEM  input  1  taken branch resolved in MEM
hlt_MEM  input  1  halt instruction in MEM
pc_hold  output  1  PC keeps its value
stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  output  1 each  hold the flop
flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  output  1 each  load a bubble (control bits zero)
halted  output  1  processor halted (sticky)
mem_timeout  output  1  sticky: wait exceeded MEM_WAIT_MAX

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- Reset (rst_n=0 at a clk edge): state=RUN, wait_cnt=0, halted=0, mem_timeout=0, counters=0.
- While rst_n=0, all stall/flush/pc_hold outputs are forced to 0.
- stall/flush/pc_hold are combinational from state and the current inputs; they act in the same cycle.
- halted and mem_timeout are registered.
- mem_busy = (we_mem_MEM | re_mem_MEM) & ~mem_rdy.
- Priority within RUN and MEM_WAIT, highest first: mem_busy > halt > branch > load-use.
- mem_busy:
  - pc_hold and stall_IF_ID/ID_EX/EX_MEM = 1; flush_MEM_WB = 1; every other output 0.
  - Next state MEM_WAIT; wait_cnt increments, saturating at 255.
  - When wait_cnt reaches MEM_WAIT_MAX, mem_timeout sets and stays set until reset; stalling continues.
  - The cycle mem_rdy=1 (mem_busy=0): no memory stall, wait_cnt clears, state returns to RUN, and lower-priority rules are evaluated that same cycle.
- halt (hlt_MEM=1, no mem_busy):
  - flush_IF_ID, flush_ID_EX, flush_EX_MEM = 1 and pc_hold = 1.
  - Next state DRAIN.
- DRAIN (exactly 1 cycle, halt instruction now in WB):
  - pc_hold and stall_IF_ID/ID_EX/EX_MEM = 1; flush_MEM_WB = 1.
  - Next state HALTED; halted=1 from that edge.
- HALTED:
  - pc_hold and all four stall outputs = 1; flushes 0.
  - Leaves only on reset; all inputs ignored.
- branch (b_ctrl_MEM=1, no mem_busy, no halt):
  - flush_IF_ID, flush_ID_EX, flush_EX_MEM = 1 for one cycle; no stall, no pc_hold (PC redirect is done externally).
  - A load-use match in the same cycle is ignored.
- load-use (none of the above):
  - Condition: re_mem_EX & we_rf_EX & (dst_addr_EX != 0) & ((p0_used_ID & p0_addr_ID==dst_addr_EX) | (p1_used_ID & p1_addr_ID==dst_addr_EX)).
  - Response: pc_hold=1, stall_IF_ID=1, flush_ID_EX=1 for exactly that cycle.
  - Next cycle the load is in MEM and the condition clears naturally.
- R0 is never a hazard source.
- Stall and flush are never both asserted for the same flop.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- When defined, add outputs perf_lu_stalls, perf_mem_waits, perf_flushes (CNT_W each). These count, respectively:
  - load-use stall cycles;
  - cycles with mem_busy;
  - branch flush events.
- Counters saturate at all-ones, clear on reset, and freeze in HALTED.
- When undefined, the ports and logic are absent; nothing else changes.

Test Plan:
- Load-use: re_mem_EX=1, we_rf_EX=1, dst_addr_EX=3, p1_used_ID=1, p1_addr_ID=3 -> exactly 1 cycle of pc_hold=1, stall_IF_ID=1, flush_ID_EX=1. Repeat with dst_addr_EX=0 -> no stall.
- Memory wait: re_mem_MEM=1 with mem_rdy low for 3 cycles, then high -> 3 cycles of stall_IF_ID/ID_EX/EX_MEM=1 and flush_MEM_WB=1; all outputs 0 on the 4th cycle; mem_timeout stays 0.
- Timeout: MEM_WAIT_MAX=4, mem_rdy low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_rdy returns, until reset.
- Branch vs load-use: b_ctrl_MEM=1 together with a load-use match -> flush_IF_ID/ID_EX/EX_MEM=1, stall_IF_ID=0, pc_hold=0. Branch during a memory wait -> flush only in the mem_rdy cycle.
- Halt: hlt_MEM=1 -> flush cycle, then a DRAIN cycle (flush_MEM_WB=1), then halted=1 with all stalls=1 held for 10+ cycles. rst_n=0 for one edge -> halted=0, state RUN.
- Reset mid-wait: rst_n low during a memory wait -> all outputs 0 immediately; after release, state RUN and wait_cnt=0. With PIPE_HAZARD_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/PC-hold sequencer for the 5-stage pipeline
// Optional performance counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       re_mem_EX,
  input  logic       we_rf_EX,
  input  logic [3:0] dst_addr_EX,
  input  logic [3:0] p0_addr_ID,
  input  logic [3:0] p1_addr_ID,
  input  logic       p0_used_ID,
  input  logic       p1_used_ID,
  input  logic       we_mem_MEM,
  input  logic       re_mem_MEM,
  input  logic       mem_rdy,
  input  logic       b_ctrl_MEM,
  input  logic       hlt_MEM,
  output logic       pc_hold,
  output logic       stall_IF_ID,
  output logic       stall_ID_EX,
  output logic       stall_EX_MEM,
  output logic       stall_MEM_WB,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       flush_EX_MEM,
  output logic       flush_MEM_WB,
  output logic       halted,
  output logic       mem_timeout
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_mem_waits,
  output logic [CNT_W-1:0] perf_flushes
`endif
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic mem_busy;
  logic load_use;
  logic busy_evt;
  logic lu_evt;
  logic br_evt;
  logic timeout_set;

  logic pc_hold_c;
  logic stall_if_id_c;
  logic stall_id_ex_c;
  logic stall_ex_mem_c;
  logic stall_mem_wb_c;
  logic flush_if_id_c;
  logic flush_id_ex_c;
  logic flush_ex_mem_c;
  logic flush_mem_wb_c;

  assign mem_busy = (we_mem_MEM | re_mem_MEM) & ~mem_rdy;

  // R0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = re_mem_EX & we_rf_EX & (dst_addr_EX != 4'd0) &
                    ((p0_used_ID & (p0_addr_ID == dst_addr_EX)) |
                     (p1_used_ID & (p1_addr_ID == dst_addr_EX)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == DRAIN) begin
        halted <= 1'b1;
      end
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    busy_evt       = 1'b0;
    lu_evt         = 1'b0;
    br_evt         = 1'b0;
    pc_hold_c      = 1'b0;
    stall_if_id_c  = 1'b0;
    stall_id_ex_c  = 1'b0;
    stall_ex_mem_c = 1'b0;
    stall_mem_wb_c = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    flush_ex_mem_c = 1'b0;
    flush_mem_wb_c = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          // Freeze everything upstream of MEM; WB receives bubbles meanwhile.
          busy_evt       = 1'b1;
          pc_hold_c      = 1'b1;
          stall_if_id_c  = 1'b1;
          stall_id_ex_c  = 1'b1;
          stall_ex_mem_c = 1'b1;
          flush_mem_wb_c = 1'b1;
          state_nxt      = MEM_WAIT;
          wait_cnt_nxt   = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          if (hlt_MEM) begin
            pc_hold_c      = 1'b1;
            flush_if_id_c  = 1'b1;
            flush_id_ex_c  = 1'b1;
            flush_ex_mem_c = 1'b1;
            state_nxt      = DRAIN;
          end else if (b_ctrl_MEM) begin
            // Younger instructions are wrong-path, so any load-use match is moot.
            br_evt         = 1'b1;
            flush_if_id_c  = 1'b1;
            flush_id_ex_c  = 1'b1;
            flush_ex_mem_c = 1'b1;
          end else if (load_use) begin
            lu_evt        = 1'b1;
            pc_hold_c     = 1'b1;
            stall_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        pc_hold_c      = 1'b1;
        stall_if_id_c  = 1'b1;
        stall_id_ex_c  = 1'b1;
        stall_ex_mem_c = 1'b1;
        flush_mem_wb_c = 1'b1;
        state_nxt      = HALTED;
      end
      HALTED: begin
        pc_hold_c      = 1'b1;
        stall_if_id_c  = 1'b1;
        stall_id_ex_c  = 1'b1;
        stall_ex_mem_c = 1'b1;
        stall_mem_wb_c = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign timeout_set = busy_evt & (wait_cnt_nxt >= WAIT_MAX);

  // Controls are held inactive while reset is asserted.
  assign pc_hold      = rst_n & pc_hold_c;
  assign stall_IF_ID  = rst_n & stall_if_id_c;
  assign stall_ID_EX  = rst_n & stall_id_ex_c;
  assign stall_EX_MEM = rst_n & stall_ex_mem_c;
  assign stall_MEM_WB = rst_n & stall_mem_wb_c;
  assign flush_IF_ID  = rst_n & flush_if_id_c;
  assign flush_ID_EX  = rst_n & flush_id_ex_c;
  assign flush_EX_MEM = rst_n & flush_ex_mem_c;
  assign flush_MEM_WB = rst_n & flush_mem_wb_c;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic cnt_en;
  assign cnt_en = (state != HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_stalls <= '0;
      perf_mem_waits <= '0;
      perf_flushes   <= '0;
    end else if (cnt_en) begin
      if (lu_evt && (perf_lu_stalls != '1)) begin
        perf_lu_stalls <= perf_lu_stalls + CNT_ONE;
      end
      if (busy_evt && (perf_mem_waits != '1)) begin
        perf_mem_waits <= perf_mem_waits + CNT_ONE;
      end
      if (br_evt && (perf_flushes != '1)) begin
        perf_flushes <= perf_flushes + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MAXW  = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       re_mem_EX, we_rf_EX;
  logic [3:0] dst_addr_EX, p0_addr_ID, p1_addr_ID;
  logic       p0_used_ID, p1_used_ID;
  logic       we_mem_MEM, re_mem_MEM, mem_rdy, b_ctrl_MEM, hlt_MEM;
  logic       pc_hold, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic       halted, mem_timeout;
  logic [CNT_W-1:0] perf_lu_stalls, perf_mem_waits, perf_flushes;

  pipe_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .re_mem_EX(re_mem_EX), .we_rf_EX(we_rf_EX), .dst_addr_EX(dst_addr_EX),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .p0_used_ID(p0_used_ID), .p1_used_ID(p1_used_ID),
    .we_mem_MEM(we_mem_MEM), .re_mem_MEM(re_mem_MEM), .mem_rdy(mem_rdy),
    .b_ctrl_MEM(b_ctrl_MEM), .hlt_MEM(hlt_MEM),
    .pc_hold(pc_hold), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_mem_waits(perf_mem_waits),
    .perf_flushes(perf_flushes)
`endif
  );

`ifndef PIPE_HAZARD_PERF_CNT_EN
  assign perf_lu_stalls = '0;
  assign perf_mem_waits = '0;
  assign perf_flushes   = '0;
`endif

  typedef struct packed {
    logic [10:0]      o;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] mw;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: mode 0 = executing, 1 = draining halt, 2 = halted.
  int m_mode, m_wait, m_lu, m_mw, m_fl;
  bit m_halted, m_to;

  function automatic int sat_inc(int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_halted = 0; m_to = 0;
    m_lu = 0; m_mw = 0; m_fl = 0;
  endtask

  task automatic idle();
    re_mem_EX = 0; we_rf_EX = 0; dst_addr_EX = 0; p0_addr_ID = 0; p1_addr_ID = 0;
    p0_used_ID = 0; p1_used_ID = 0; we_mem_MEM = 0; re_mem_MEM = 0;
    mem_rdy = 0; b_ctrl_MEM = 0; hlt_MEM = 0;
  endtask

  // Predict this cycle's outputs, queue them, advance the model, then clock.
  task automatic step();
    bit pc, s1, s2, s3, s4, f1, f2, f3, f4, lu, busy;
    exp_t e;
    {pc, s1, s2, s3, s4, f1, f2, f3, f4} = '0;
    lu = re_mem_EX && we_rf_EX && dst_addr_EX != 0 &&
         ((p0_used_ID && p0_addr_ID == dst_addr_EX) ||
          (p1_used_ID && p1_addr_ID == dst_addr_EX));
    busy = (we_mem_MEM || re_mem_MEM) && !mem_rdy;
    if (rst_n) begin
      if (m_mode == 2)      {pc, s1, s2, s3, s4} = 5'b11111;
      else if (m_mode == 1) {pc, s1, s2, s3, f4} = 5'b11111;
      else if (busy)        {pc, s1, s2, s3, f4} = 5'b11111;
      else if (hlt_MEM)     {pc, f1, f2, f3} = 4'b1111;
      else if (b_ctrl_MEM)  {f1, f2, f3} = 3'b111;
      else if (lu)          {pc, s1, f2} = 3'b111;
    end
    e.o  = {pc, s1, s2, s3, s4, f1, f2, f3, f4, m_halted, m_to};
    e.lu = CNT_W'(m_lu);
    e.mw = CNT_W'(m_mw);
    e.fl = CNT_W'(m_fl);
    exp_q.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == 1) begin
      m_mode = 2; m_halted = 1;
    end else if (m_mode == 0) begin
      if (busy) begin
        m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        if (m_wait >= MAXW) m_to = 1;
        m_mw = sat_inc(m_mw);
      end else begin
        m_wait = 0;
        if (hlt_MEM)         m_mode = 1;
        else if (b_ctrl_MEM) m_fl = sat_inc(m_fl);
        else if (lu)         m_lu = sat_inc(m_lu);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] got;
      e   = exp_q.pop_front();
      got = {pc_hold, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted, mem_timeout};
      n_checks++;
      if (got !== e.o) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %b expected %b (pc,s1-4,f1-4,halted,timeout)",
                 cyc, got, e.o);
      end
`ifdef PIPE_HAZARD_PERF_CNT_EN
      n_checks++;
      if (perf_lu_stalls !== e.lu || perf_mem_waits !== e.mw || perf_flushes !== e.fl) begin
        n_fail++;
        $display("FAIL perf cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 cyc, perf_lu_stalls, perf_mem_waits, perf_flushes, e.lu, e.mw, e.fl);
      end
`endif
    end
  end

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    steps(2);
    rst_n = 1;
    steps(2);

    // Load-use on p1, then the same with R0 as destination.
    re_mem_EX = 1; we_rf_EX = 1; dst_addr_EX = 3; p1_used_ID = 1; p1_addr_ID = 3;
    step();
    idle(); step();
    re_mem_EX = 1; we_rf_EX = 1; dst_addr_EX = 0; p1_used_ID = 1; p1_addr_ID = 0;
    step();
    idle(); step();

    // Three-cycle memory wait, below the timeout threshold.
    re_mem_MEM = 1; steps(3);
    mem_rdy = 1; step();
    idle(); steps(2);

    // Six-cycle wait trips the sticky timeout.
    we_mem_MEM = 1; steps(6);
    mem_rdy = 1; step();
    idle(); steps(3);
    rst_n = 0; step();
    rst_n = 1; step();

    // Branch together with a load-use match.
    b_ctrl_MEM = 1; re_mem_EX = 1; we_rf_EX = 1; dst_addr_EX = 5;
    p0_used_ID = 1; p0_addr_ID = 5;
    step();
    idle(); step();

    // Branch held during a memory wait.
    b_ctrl_MEM = 1; re_mem_MEM = 1; steps(2);
    mem_rdy = 1; step();
    idle(); step();

    // Halt, drain, then stay halted despite activity.
    hlt_MEM = 1; step();
    idle(); step();
    re_mem_MEM = 1; b_ctrl_MEM = 1; steps(12);
    idle();
    rst_n = 0; step();
    rst_n = 1; steps(2);

    // Reset in the middle of a memory wait.
    re_mem_MEM = 1; steps(2);
    rst_n = 0; step();
    rst_n = 1; idle(); steps(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      re_mem_EX   = 1'($urandom % 2);
      we_rf_EX    = 1'($urandom % 4 != 0);
      dst_addr_EX = 4'($urandom % 4);
      p0_addr_ID  = 4'($urandom % 4);
      p1_addr_ID  = 4'($urandom % 4);
      p0_used_ID  = 1'($urandom % 2);
      p1_used_ID  = 1'($urandom % 2);
      we_mem_MEM  = 1'($urandom % 4 == 0);
      re_mem_MEM  = 1'($urandom % 4 == 0);
      mem_rdy     = 1'($urandom % 3 != 0);
      b_ctrl_MEM  = 1'($urandom % 5 == 0);
      hlt_MEM     = 1'($urandom % 80 == 0);
      rst_n       = ($urandom % 40 != 0);
      step();
    end
    idle();
    rst_n = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
